// File: rtl/map_draw_sequencer_pkg.sv
// map_pkg: shared map geometry, screen constants and sequencer state encoding
package map_pkg;
  localparam int NUM_RECTS = 21;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
  } point_t;
  typedef struct packed {
    point_t top_left;
    point_t bottom_right;
  } rect_t;
  typedef enum logic [2:0] {S_idle, S_wait_map, S_scan, S_emit, S_done} state_t;
endpackage

// File: rtl/map_draw_sequencer_in_rect_bounds.sv
// in_rect_bounds: flags a point lying on a rectangle outline, corners excluded
module in_rect_bounds
  import map_pkg::*;
(
  input  point_t p,
  input  point_t top_left,
  input  point_t bottom_right,
  output logic   hit
);
  assign hit = ((p.x == top_left.x || p.x == bottom_right.x) && p.y > top_left.y && p.y < bottom_right.y) ||
               ((p.y == top_left.y || p.y == bottom_right.y) && p.x > top_left.x && p.x < bottom_right.x);
endmodule

// File: rtl/map_draw_sequencer.sv
// map_draw_sequencer: raster-scans the screen testing each pixel against every map rectangle outline; MAP_DRAW_EARLY_EXIT_EN ends a pixel's scan at its first hit
module map_draw_sequencer
  import map_pkg::*;
#(
  parameter int NUM_RECTS = map_pkg::NUM_RECTS,
  parameter int SCREEN_W = map_pkg::SCREEN_W,
  parameter int SCREEN_H = map_pkg::SCREEN_H,
  localparam int IW = $clog2(NUM_RECTS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          map_ready,
  output logic [IW-1:0] rect_idx,
  input  logic [37:0]   rect_data,
  output logic [9:0]    px_x,
  output logic [8:0]    px_y,
  output logic          px_wall,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          busy,
  output logic          done
);
  state_t state, state_n;
  rect_t rect;
  logic hit_now, last_rect, last_x, last_px, scan_end;
  assign rect = rect_t'(rect_data);
  assign last_rect = rect_idx == IW'(NUM_RECTS - 1);
  assign last_x = px_x == 10'(SCREEN_W - 1);
  assign last_px = last_x && px_y == 9'(SCREEN_H - 1);
`ifdef MAP_DRAW_EARLY_EXIT_EN
  assign scan_end = last_rect || hit_now;
`else
  assign scan_end = last_rect;
`endif
  assign px_valid = state == S_emit;
  assign busy = state != S_idle;
  assign done = state == S_done;
  in_rect_bounds u_edge (
    .p(point_t'({px_x, px_y})),
    .top_left(rect.top_left),
    .bottom_right(rect.bottom_right),
    .hit(hit_now)
  );
  // state register
  always_ff @(posedge clk)
    state <= reset ? S_idle : state_n;
  // control flow: wait for the table, scan rectangles, hand the pixel off, finish
  always_comb begin
    state_n = state;
    case (state)
      S_idle: if (start) state_n = map_ready ? S_scan : S_wait_map;
      S_wait_map: if (map_ready) state_n = S_scan;
      S_scan: if (scan_end) state_n = S_emit;
      S_emit: if (px_ready) state_n = last_px ? S_done : S_scan;
      default: state_n = S_idle;
    endcase
  end
  // pixel position, rectangle index and hit accumulator; the last pixel wraps both coordinates back to 0
  always_ff @(posedge clk)
    if (reset) begin
      rect_idx <= '0;
      px_x <= '0;
      px_y <= '0;
      px_wall <= 1'b0;
    end else case (state)
      S_scan: begin
        px_wall <= px_wall | hit_now;
        if (!scan_end) rect_idx <= rect_idx + 1'b1;
      end
      S_emit: if (px_ready) begin
        px_wall <= 1'b0;
        rect_idx <= '0;
        px_x <= last_x ? '0 : px_x + 1'b1;
        px_y <= last_px ? '0 : last_x ? px_y + 1'b1 : px_y;
      end
      default: ;
    endcase
endmodule

// File: doc/map_draw_sequencer.md
Name: map_draw_sequencer

Overview:
- Sequences whole-screen rendering of the maze walls once the rectangle table has been loaded.
- Raster-scans every pixel. For each pixel, checks it against each rectangle outline in turn, one rectangle per cycle, through a single shared edge checker.
- Emits one wall/no-wall pixel result per pixel over a valid/ready handshake to the framebuffer writer.
- Sits between the map table loader and the framebuffer write port.

Parameters:
- NUM_RECTS, 21, number of rectangle entries in the map table (index width = $clog2(NUM_RECTS)).
- SCREEN_W, 640, pixels per line; x range 0..SCREEN_W-1.
- SCREEN_H, 480, lines per frame; y range 0..SCREEN_H-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request one full-frame render; sampled only in S_idle
- map_ready  in  1  rectangle table fully loaded; level signal
- rect_idx  out  $clog2(NUM_RECTS)  index into the rectangle table
- rect_data  in  38  entry at rect_idx, same-cycle combinational read; [37:19] top-left {x[9:0],y[8:0]}, [18:0] bottom-right {x,y}
- px_x  out  10  current pixel x
- px_y  out  9  current pixel y
- px_wall  out  1  pixel lies on any rectangle outline
- px_valid  out  1  px_x/px_y/px_wall valid
- px_ready  in  1  framebuffer accepts pixel
- busy  out  1  high in every state except S_idle
- done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (any state, including mid-frame): state S_idle; rect_idx=0, px_x=0, px_y=0, px_wall=0, px_valid=0, busy=0, done=0; hit accumulator cleared.
- Hit test (combinational, per cycle): hit_now = ((x==x0 | x==x1) & y>y0 & y<y1) | ((y==y0 | y==y1) & x>x0 & x<x1).
  - Comparisons are unsigned and strict.
  - Rectangle corners are not walls.
- S_idle:
  - start & map_ready -> S_scan.
  - start & !map_ready -> S_wait_map.
  - Otherwise stay in S_idle.
- S_wait_map: -> S_scan when map_ready. start is ignored here.
- S_scan:
  - Each cycle: hit <= hit | hit_now; rect_idx increments.
  - Leave to S_emit after evaluating rect_idx==NUM_RECTS-1; px_wall then equals the final OR.
  - On exit, rect_idx holds its value.
- S_emit:
  - px_valid=1; px_x, px_y, px_wall held stable until px_ready.
  - On px_valid & px_ready at the last pixel (SCREEN_W-1, SCREEN_H-1) -> S_done.
  - On px_valid & px_ready at any other pixel: advance x. At x==SCREEN_W-1, wrap x to 0 and increment y. Clear hit, set rect_idx=0, -> S_scan.
  - px_valid deasserts in the cycle after acceptance.
- S_done: done=1 for exactly one cycle; px_x=0, px_y=0 restored; -> S_idle.
- Latency: with px_ready held high, each pixel takes NUM_RECTS scan cycles + 1 emit cycle. A full frame is SCREEN_W*SCREEN_H*(NUM_RECTS+1) cycles from start to done.
- start while busy is ignored. No frame restarts except via reset.
- map_ready dropping mid-frame is ignored. Table stability is the loader's responsibility.

Optional Feature:
- Macro: MAP_DRAW_EARLY_EXIT_EN.
- Defined: S_scan exits to S_emit in the cycle hit_now first asserts. A pixel hit at index k spends k+1 scan cycles. Non-hit pixels are unchanged.
- Undefined: always NUM_RECTS scan cycles per pixel, giving deterministic frame time.
- px_wall results are identical either way.

Decomposition:
- Package map_pkg holds:
  - constants NUM_RECTS, SCREEN_W, SCREEN_H;
  - typedef point_t (packed {x[9:0], y[8:0]});
  - typedef rect_t (packed {point_t top_left, point_t bottom_right});
  - the state enum.
- One sub-module: the existing in_rect_bounds edge checker, instantiated once for hit_now. It is fed {px_x,px_y} and the two fields of rect_data.

Test Plan (bench parameters SCREEN_W=32, SCREEN_H=24, NUM_RECTS=21; rect 0 = (10,10)-(20,20); all other entries = (0,0)-(0,0), which never hit; px_ready=1 unless stated):
- Edge detection: pixel (10,15) -> px_wall=1; (15,10) -> 1; (15,15) -> 0; (10,10) corner -> 0; (21,15) -> 0.
- Frame count: start with map_ready=1 -> exactly 768 accepted pixels, then done pulses once. Without the early-exit macro, done arrives 768*22 cycles after start.
- Backpressure: px_ready low 5 cycles at pixel (3,0) -> px_valid and pixel fields held stable, no skipped or repeated pixel, next pixel (4,0).
- Wait for map: start with map_ready=0 -> busy=1, rect_idx=0, no px_valid. Raise map_ready at cycle 10 -> scan starts next cycle.
- Reset mid-frame at pixel (5,7) -> next cycle S_idle, all outputs 0. A new start renders from (0,0).
- Early exit (macro defined): pixel (10,15) hit at index 0 -> px_valid asserted 2 cycles after the scan begins. A non-hit pixel still takes 21 scan cycles.
